// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze/flush/bubble sequencing with stall and flush counters
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam bit MULTI_CYCLE = (MEM_LAT > 1);

  typedef enum logic [1:0] {RUN, WAIT, LAST} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic freeze;
  logic hazard;
  logic branch_flush;
  logic load_use_stall;

  // Freeze is a function of the wait state; LAST lets the held access complete
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      RUN:     freeze = mem_req && MULTI_CYCLE;
      WAIT:    freeze = 1'b1;
      LAST:    freeze = 1'b0;
      default: freeze = 1'b0;
    endcase
  end

  // Hazard conditions in priority order: freeze, then branch, then load-use
  always_comb begin
    hazard = ex_MemRead && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
              (id_uses_rs2 && (id_rs2 == ex_rd)));
    branch_flush   = !freeze && ex_branch_taken;
    load_use_stall = !freeze && !ex_branch_taken && hazard;
  end

  // Enable/flush/bubble outputs; everything held low while reset is asserted
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b0;
    mem_busy     = 1'b0;
    if (!reset) begin
      if (freeze) begin
        mem_busy = 1'b1;
      end else if (branch_flush) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_write = 1'b1;
      end else if (load_use_stall) begin
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_write = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
      end
    end
  end

  // Memory-wait FSM and wrapping performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            if (MEM_LAT == 2) begin
              state_q <= LAST;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(MEM_LAT - 3);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= LAST;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        LAST:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (freeze || load_use_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch_flush)             flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
